// File: rtl/countdown_pkg.sv
// Shared types, constants and load-value clamps for the countdown controller.
// Pure definitions: no latency, no flow control.
package countdown_pkg;

    localparam int SECONDS_PER_MINUTE = 60;
    localparam int SECONDS_WIDTH      = 6;

    typedef enum logic [1:0] {
        CD_IDLE    = 2'd0,
        CD_RUNNING = 2'd1,
        CD_PAUSED  = 2'd2,
        CD_EXPIRED = 2'd3
    } countdown_state_t;

    function automatic logic [SECONDS_WIDTH-1:0] clamp_seconds(input logic [SECONDS_WIDTH-1:0] value);
        localparam logic [SECONDS_WIDTH-1:0] MAX_SECONDS = SECONDS_WIDTH'(SECONDS_PER_MINUTE - 1);
        return (value > MAX_SECONDS) ? MAX_SECONDS : value;
    endfunction

    function automatic int unsigned clamp_minutes(input int unsigned value, input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/marker_edge_detect.sv
// Synchronises the held seconds-marker level and flags its rising edge.
// rise_o is combinational from two flops (one cycle after the sync stage); no backpressure.
module marker_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic marker_i,
    output logic rise_o
);

    logic sync_q;
    logic hist_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= marker_i;
            hist_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/countdown_controller.sv
// Minutes:seconds countdown driven by the seconds timer marker; optional COUNTDOWN_AUTO_RELOAD_EN.
// Requests act one cycle after sampling; marker-to-decrement is two edges; no backpressure.
module countdown_controller
    import countdown_pkg::*;
#(
    parameter  int MAX_MINUTES = 99,
    localparam int MW          = $clog2(MAX_MINUTES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     secondMarker,
    output logic                     timerEnable,
    output logic                     timerRestart,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     load,
    input  logic [MW-1:0]            loadMinutes,
    input  logic [SECONDS_WIDTH-1:0] loadSeconds,
    output logic [MW-1:0]            minutes,
    output logic [SECONDS_WIDTH-1:0] seconds,
    output logic                     expired,
    output logic [1:0]               state
);

    localparam logic [SECONDS_WIDTH-1:0] LAST_SECOND = SECONDS_WIDTH'(SECONDS_PER_MINUTE - 1);

    countdown_state_t         state_q, state_d;
    logic [MW-1:0]            mins_q, mins_d;
    logic [SECONDS_WIDTH-1:0] secs_q, secs_d;
    logic                     restart_q, restart_d;
    logic                     expired_q, expired_d;
    logic                     expire_pulse;
    logic                     marker_rise;
    logic                     tick;
    logic [MW-1:0]            load_mins;
    logic [SECONDS_WIDTH-1:0] load_secs;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [MW-1:0]            reload_mins_q, reload_mins_d;
    logic [SECONDS_WIDTH-1:0] reload_secs_q, reload_secs_d;
`endif

    marker_edge_detect u_marker_edge_detect (
        .clock    (clock),
        .reset    (reset),
        .marker_i (secondMarker),
        .rise_o   (marker_rise)
    );

    assign tick      = marker_rise && (state_q == CD_RUNNING);
    assign load_mins = MW'(clamp_minutes(32'(loadMinutes), 32'(MAX_MINUTES)));
    assign load_secs = clamp_seconds(loadSeconds);

    always_comb begin
        state_d      = state_q;
        mins_d       = mins_q;
        secs_d       = secs_q;
        restart_d    = 1'b0;
        expire_pulse = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_mins_d = reload_mins_q;
        reload_secs_d = reload_secs_q;
`endif
        // Load is ignored while running, so pause/tick still apply in that case.
        if (load && (state_q != CD_RUNNING)) begin
            mins_d    = load_mins;
            secs_d    = load_secs;
            state_d   = CD_IDLE;
            restart_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_mins_d = load_mins;
            reload_secs_d = load_secs;
`endif
        end else if (tick) begin
            restart_d = 1'b1;
            if (secs_q != '0) begin
                secs_d = secs_q - SECONDS_WIDTH'(1);
            end else if (mins_q != '0) begin
                mins_d = mins_q - MW'(1);
                secs_d = LAST_SECOND;
            end
            if ((mins_d == '0) && (secs_d == '0)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if ((reload_mins_q != '0) || (reload_secs_q != '0)) begin
                    mins_d       = reload_mins_q;
                    secs_d       = reload_secs_q;
                    expire_pulse = 1'b1;
                    if (pause) begin
                        state_d = CD_PAUSED;
                    end
                end else begin
                    state_d = CD_EXPIRED;
                end
`else
                state_d = CD_EXPIRED;
`endif
            end else if (pause) begin
                state_d = CD_PAUSED;
            end
        end else if (pause && (state_q == CD_RUNNING)) begin
            state_d = CD_PAUSED;
        end else if (start && ((state_q == CD_IDLE) || (state_q == CD_PAUSED))
                     && ((mins_q != '0) || (secs_q != '0))) begin
            state_d = CD_RUNNING;
        end
        expired_d = (state_d == CD_EXPIRED) || expire_pulse;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= CD_IDLE;
            mins_q    <= '0;
            secs_q    <= '0;
            restart_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            restart_q <= restart_d;
            expired_q <= expired_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reload_mins_q <= '0;
            reload_secs_q <= '0;
        end else begin
            reload_mins_q <= reload_mins_d;
            reload_secs_q <= reload_secs_d;
        end
    end
`endif

    assign timerEnable  = (state_q == CD_RUNNING);
    assign timerRestart = restart_q;
    assign minutes      = mins_q;
    assign seconds      = secs_q;
    assign expired      = expired_q;
    assign state        = state_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Directed bench for countdown_controller: hand-computed values, sampled on the falling edge.
// Marker pulses are held for a fixed window, mimicking a timer waiting to be re-armed.
module tb_countdown_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       secondMarker = 1'b0;
    logic       timerEnable;
    logic       timerRestart;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [6:0] loadMinutes = '0;
    logic [5:0] loadSeconds = '0;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       expired;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int rs;

    countdown_controller #(.MAX_MINUTES(99)) dut (
        .clock        (clock),
        .reset        (reset),
        .secondMarker (secondMarker),
        .timerEnable  (timerEnable),
        .timerRestart (timerRestart),
        .start        (start),
        .pause        (pause),
        .load         (load),
        .loadMinutes  (loadMinutes),
        .loadSeconds  (loadSeconds),
        .minutes      (minutes),
        .seconds      (seconds),
        .expired      (expired),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic req(input logic ld, input logic pa, input logic st,
                       input logic [6:0] lm, input logic [5:0] ls);
        @(negedge clock);
        load = ld; pause = pa; start = st;
        loadMinutes = lm; loadSeconds = ls;
        @(negedge clock);
        load = 1'b0; pause = 1'b0; start = 1'b0;
    endtask

    // One marker period of 20 cycles; counts re-arm pulses seen.
    task automatic send_tick(output int restarts);
        restarts = 0;
        @(negedge clock);
        secondMarker = 1'b1;
        repeat (12) begin
            @(negedge clock);
            restarts += int'(timerRestart);
        end
        secondMarker = 1'b0;
        repeat (7) begin
            @(negedge clock);
            restarts += int'(timerRestart);
        end
    endtask

    task automatic chk_value(input string tag, input int m, input int s, input int st);
        chk({tag, "_min"}, 32'(minutes), 32'(m));
        chk({tag, "_sec"}, 32'(seconds), 32'(s));
        chk({tag, "_state"}, 32'(state), 32'(st));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_value("reset", 0, 0, 0);
        chk("reset_expired", 32'(expired), 0);
        chk("reset_enable", 32'(timerEnable), 0);
        chk("reset_restart", 32'(timerRestart), 0);
        reset = 1'b1;

        // Load 0:03, run down to expiry with exact tick timing on the first marker.
        req(1'b1, 1'b0, 1'b0, 7'd0, 6'd3);
        chk_value("load3", 0, 3, 0);
        chk("load3_restart", 32'(timerRestart), 1);
        @(negedge clock);
        chk("load3_restart_low", 32'(timerRestart), 0);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        chk("start_state", 32'(state), 1);
        chk("start_enable", 32'(timerEnable), 1);

        secondMarker = 1'b1;
        @(negedge clock);
        chk("t1_not_early", 32'(seconds), 3);
        chk("t1_restart_early", 32'(timerRestart), 0);
        @(negedge clock);
        chk("t1_sec", 32'(seconds), 2);
        chk("t1_restart", 32'(timerRestart), 1);
        @(negedge clock);
        chk("t1_restart_one_cycle", 32'(timerRestart), 0);
        repeat (8) @(negedge clock);
        secondMarker = 1'b0;
        repeat (8) @(negedge clock);

        send_tick(rs);
        chk("t2_sec", 32'(seconds), 1);
        chk("t2_restarts", 32'(rs), 1);
        send_tick(rs);
        chk_value("t3", 0, 0, 3);
        chk("t3_expired", 32'(expired), 1);
        chk("t3_restarts", 32'(rs), 1);
        chk("t3_enable", 32'(timerEnable), 0);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        chk("expired_start_ignored", 32'(state), 3);

        // Minute borrow, then a long-held marker yields one decrement.
        req(1'b1, 1'b0, 1'b0, 7'd1, 6'd0);
        chk("load100_expired_clear", 32'(expired), 0);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        send_tick(rs);
        chk_value("borrow", 0, 59, 1);
        rs = 0;
        @(negedge clock);
        secondMarker = 1'b1;
        repeat (50) begin
            @(negedge clock);
            rs += int'(timerRestart);
        end
        secondMarker = 1'b0;
        repeat (3) @(negedge clock);
        chk_value("held", 0, 58, 1);
        chk("held_restarts", 32'(rs), 1);

        // Pause and tick land in the same cycle.
        req(1'b1, 1'b1, 1'b0, 7'd0, 6'd0);
        chk_value("running_pause", 0, 58, 2);
        req(1'b1, 1'b0, 1'b0, 7'd2, 6'd30);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        @(negedge clock);
        secondMarker = 1'b1;
        @(negedge clock);
        pause = 1'b1;
        @(negedge clock);
        pause = 1'b0;
        chk_value("pause_tick", 2, 29, 2);
        repeat (10) @(negedge clock);
        secondMarker = 1'b0;
        repeat (5) @(negedge clock);
        send_tick(rs);
        chk_value("paused_tick", 2, 29, 2);
        chk("paused_restarts", 32'(rs), 0);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        chk("resume_state", 32'(state), 1);
        send_tick(rs);
        chk_value("resume_tick", 2, 28, 1);

        // Load is ignored while running.
        req(1'b1, 1'b0, 1'b0, 7'd5, 6'd5);
        chk_value("run_load", 2, 28, 1);
        chk("run_load_restart", 32'(timerRestart), 0);
        req(1'b0, 1'b1, 1'b0, 7'd0, 6'd0);
        chk("pause_enable", 32'(timerEnable), 0);

        // Clamping and request priority.
        req(1'b1, 1'b0, 1'b0, 7'd120, 6'd63);
        chk_value("clamp", 99, 59, 0);
        req(1'b1, 1'b1, 1'b1, 7'd0, 6'd5);
        chk_value("priority", 0, 5, 0);
        req(1'b1, 1'b0, 1'b0, 7'd0, 6'd0);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        chk_value("zero_start", 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        req(1'b1, 1'b0, 1'b0, 7'd0, 6'd2);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        send_tick(rs);
        chk_value("ar_t1", 0, 1, 1);
        @(negedge clock);
        secondMarker = 1'b1;
        repeat (2) @(negedge clock);
        chk_value("ar_reload", 0, 2, 1);
        chk("ar_expired_pulse", 32'(expired), 1);
        @(negedge clock);
        chk("ar_expired_low", 32'(expired), 0);
        repeat (8) @(negedge clock);
        secondMarker = 1'b0;
        repeat (8) @(negedge clock);
`endif

        // Asynchronous reset mid-count.
        req(1'b1, 1'b0, 1'b0, 7'd0, 6'd10);
        req(1'b0, 1'b0, 1'b1, 7'd0, 6'd0);
        send_tick(rs);
        chk_value("pre_rst", 0, 9, 1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk_value("async_rst", 0, 0, 0);
        chk("async_rst_enable", 32'(timerEnable), 0);
        chk("async_rst_expired", 32'(expired), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_value("post_rst", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
